// File: rtl/sb_config_loader_pkg.sv
`default_nettype none
// ============================================================================
// Module      : sb_config_loader_pkg
// Description : Shared types and sizing helpers for the switch box config
//               loader: FSM state encoding, config width and word count.
// Revision    : 1.0 - initial release
// ============================================================================
package sb_config_loader_pkg;

  // Loader FSM states; encoding is fixed so that debug taps read 0..3.
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_LOAD   = 2'd1,
    ST_CHECK  = 2'd2,
    ST_COMMIT = 2'd3
  } state_t;

  // SwitchBox config width: every LUT input of every LE in the cluster
  // selects among the IC_PAIRS interconnect pairs plus one local feedback.
  function automatic int sb_conf(input int ic_pairs, input int cluster, input int lut_size);
    return cluster * lut_size * (ic_pairs + 1);
  endfunction

  // Number of stream words needed to cover conf_w bits (ceiling division).
  function automatic int sb_cfg_words(input int conf_w, input int word_w);
    return (conf_w + word_w - 1) / word_w;
  endfunction

endpackage : sb_config_loader_pkg
`default_nettype wire

// File: rtl/sb_config_loader_cfg_word_shadow.sv
`default_nettype none
// ============================================================================
// Module      : cfg_word_shadow
// Description : CONF_W-bit shadow register written one stream word at a
//               time. The last word is truncated to the bits that fit.
// Revision    : 1.0 - initial release
// ============================================================================
module cfg_word_shadow #(
  parameter int CONF_W = 264,
  parameter int WORD_W = 8,
  parameter int NWORDS = 33,
  parameter int CNT_W  = 6
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_we,
  input  logic [CNT_W-1:0]  i_idx,
  input  logic [WORD_W-1:0] i_word,
  output logic [CONF_W-1:0] o_shadow
);

  for (genvar w = 0; w < NWORDS; w++) begin : g_word
    localparam int LO = w * WORD_W;
    localparam int W  = ((CONF_W - LO) < WORD_W) ? (CONF_W - LO) : WORD_W;

    logic [W-1:0] r_word;

    // Capture the word slot addressed by i_idx; upper bits of a short last slot are dropped.
    always_ff @(posedge clk) begin
      if (rst) begin
        r_word <= '0;
      end else if (i_we && (i_idx == CNT_W'(w))) begin
        r_word <= i_word[W-1:0];
      end
    end

    assign o_shadow[LO +: W] = r_word;
  end : g_word

endmodule : cfg_word_shadow
`default_nettype wire

// File: rtl/sb_config_loader.sv
`default_nettype none
// ============================================================================
// Module      : sb_config_loader
// Description : Assembles a SYNC-framed, XOR-checksummed word stream into a
//               shadow register and commits it atomically to config_out.
// Revision    : 1.0 - initial release
// ============================================================================
module sb_config_loader
  import sb_config_loader_pkg::*;
#(
  parameter int              IC_PAIRS  = 10,
  parameter int              CLUSTER   = 4,
  parameter int              LUT_SIZE  = 6,
  parameter int              WORD_W    = 8,
  parameter logic [WORD_W-1:0] SYNC_WORD = WORD_W'(8'hA5),
  localparam int             CONF_W    = sb_conf(IC_PAIRS, CLUSTER, LUT_SIZE),
  localparam int             NWORDS    = sb_cfg_words(CONF_W, WORD_W),
  localparam int             CNT_W     = $clog2(NWORDS + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [WORD_W-1:0] s_data,
  input  logic              s_valid,
  output logic              s_ready,
  output logic [CONF_W-1:0] config_out,
  output logic              cfg_valid,
  output logic              cfg_done,
  output logic              cfg_error,
  output logic              busy
);

  state_t              r_state;
  logic [CNT_W-1:0]    r_cnt;
  logic [WORD_W-1:0]   r_xor;
  logic                r_rdy;
  logic [CONF_W-1:0]   r_cfg;
  logic                r_valid;
  logic                r_done;
  logic                r_err;
  logic                r_busy;
  logic [CONF_W-1:0]   w_shadow;
  logic                w_fire;
  logic                w_we;

  // Ready is forced low during reset so nothing is accepted on a reset edge.
  assign s_ready = r_rdy & ~rst;
  assign w_fire  = s_valid & s_ready;
  assign w_we    = (r_state == ST_LOAD) & w_fire;

  cfg_word_shadow #(
    .CONF_W (CONF_W),
    .WORD_W (WORD_W),
    .NWORDS (NWORDS),
    .CNT_W  (CNT_W)
  ) u_shadow (
    .clk      (clk),
    .rst      (rst),
    .i_we     (w_we),
    .i_idx    (r_cnt),
    .i_word   (s_data),
    .o_shadow (w_shadow)
  );

  // Frame FSM: sync hunt, payload load with running XOR, checksum, commit.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
      r_xor   <= '0;
      r_rdy   <= 1'b1;
      r_cfg   <= '0;
      r_valid <= 1'b0;
      r_done  <= 1'b0;
      r_err   <= 1'b0;
      r_busy  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_fire && (s_data == SYNC_WORD)) begin
            r_state <= ST_LOAD;
            r_cnt   <= '0;
            r_xor   <= '0;
            r_err   <= 1'b0;
            r_busy  <= 1'b1;
          end
        end
        ST_LOAD: begin
          if (w_fire) begin
            r_xor <= r_xor ^ s_data;
            r_cnt <= r_cnt + CNT_W'(1);
            if (r_cnt == CNT_W'(NWORDS - 1)) begin
              r_state <= ST_CHECK;
            end
          end
        end
        ST_CHECK: begin
          if (w_fire) begin
            if (s_data == r_xor) begin
              r_state <= ST_COMMIT;
              r_rdy   <= 1'b0;
            end else begin
              r_state <= ST_IDLE;
              r_err   <= 1'b1;
              r_busy  <= 1'b0;
            end
          end
        end
        ST_COMMIT: begin
          r_cfg   <= w_shadow;
          r_valid <= 1'b1;
          r_done  <= 1'b1;
          r_rdy   <= 1'b1;
          r_busy  <= 1'b0;
          r_state <= ST_IDLE;
        end
        default: begin
          r_state <= ST_IDLE;
          r_rdy   <= 1'b1;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign config_out = r_cfg;
  assign cfg_valid  = r_valid;
  assign cfg_done   = r_done;
  assign cfg_error  = r_err;
  assign busy       = r_busy;

endmodule : sb_config_loader
`default_nettype wire

// File: tb/tb_sb_config_loader.sv
`default_nettype none
// ============================================================================
// Module      : tb_sb_config_loader
// Description : Scoreboard bench for sb_config_loader, 8-bit and 16-bit
//               stream widths.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_sb_config_loader;

  logic         clk = 1'b0;
  logic         rst;
  always #5 clk = ~clk;

  logic [7:0]   s_data8;
  logic         s_valid8, s_ready8, valid8, done8, err8, busy8;
  logic [263:0] cfg8;
  logic [15:0]  s_data16;
  logic         s_valid16, s_ready16, valid16, done16, err16, busy16;
  logic [263:0] cfg16;

  sb_config_loader dut8 (
    .clk(clk), .rst(rst), .s_data(s_data8), .s_valid(s_valid8), .s_ready(s_ready8),
    .config_out(cfg8), .cfg_valid(valid8), .cfg_done(done8), .cfg_error(err8), .busy(busy8)
  );

  sb_config_loader #(.WORD_W(16), .SYNC_WORD(16'h00A5)) dut16 (
    .clk(clk), .rst(rst), .s_data(s_data16), .s_valid(s_valid16), .s_ready(s_ready16),
    .config_out(cfg16), .cfg_valid(valid16), .cfg_done(done16), .cfg_error(err16), .busy(busy16)
  );

  int           n_chk  = 0;
  int           n_fail = 0;
  logic [263:0] q8[$];
  logic [263:0] q16[$];
  logic [15:0]  pl [0:32];

  task automatic chkw(input string nm, input logic [263:0] act, input logic [263:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic chk8(input string nm, input logic [7:0] act, input logic [7:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic chk1(input string nm, input logic act, input logic exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b", nm, act, exp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Present one word from a negedge and hold it until a handshake edge.
  task automatic send(input bit w16, input logic [15:0] d);
    bit ok;
    ok = 1'b0;
    if (w16) begin
      s_valid16 = 1'b1;
      s_data16  = d;
    end else begin
      s_valid8 = 1'b1;
      s_data8  = d[7:0];
    end
    for (int t = 0; t < 50 && !ok; t++) begin
      if (w16 ? s_ready16 : s_ready8) begin
        @(posedge clk);
        ok = 1'b1;
      end
      @(negedge clk);
    end
    s_valid8  = 1'b0;
    s_valid16 = 1'b0;
    if (!ok) begin
      n_chk++;
      n_fail++;
      $display("FAIL handshake: got no s_ready expected s_ready within 50 cycles");
    end
  endtask

  // Sync + payload from pl[] + checksum; expected commit goes to the scoreboard.
  task automatic frame(input bit w16, input bit use_chk, input logic [15:0] chk_v,
                       input int max_gap, input bit chk_err_clear);
    int           nw;
    logic [15:0]  x;
    logic [263:0] e;
    logic [15:0]  c;
    nw = w16 ? 17 : 33;
    x  = '0;
    e  = '0;
    send(w16, 16'h00A5);
    if (chk_err_clear) chk1("cfg_error_cleared_on_sync", w16 ? err16 : err8, 1'b0);
    for (int k = 0; k < nw; k++) begin
      send(w16, pl[k]);
      x = x ^ pl[k];
      if (w16) begin
        if (k < 16) e[k*16 +: 16] = pl[k];
        else        e[256 +: 8]   = pl[k][7:0];
      end else begin
        e[k*8 +: 8] = pl[k][7:0];
      end
      if (max_gap > 0) idle($urandom_range(0, max_gap));
    end
    c = use_chk ? chk_v : x;
    if (c == x) begin
      if (w16) q16.push_back(e);
      else     q8.push_back(e);
    end
    send(w16, c);
  endtask

  // Monitor: every commit pulse must match the oldest expected frame.
  always @(negedge clk) begin
    logic [263:0] e;
    if (!rst && done8 === 1'b1) begin
      if (q8.size() == 0) begin
        n_chk++; n_fail++;
        $display("FAIL cfg_done8: got unexpected commit expected none");
      end else begin
        e = q8.pop_front();
        chkw("config_out8", cfg8, e);
        chk1("cfg_valid8", valid8, 1'b1);
      end
    end
    if (!rst && done16 === 1'b1) begin
      if (q16.size() == 0) begin
        n_chk++; n_fail++;
        $display("FAIL cfg_done16: got unexpected commit expected none");
      end else begin
        e = q16.pop_front();
        chkw("config_out16", cfg16, e);
        chk1("cfg_valid16", valid16, 1'b1);
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; s_valid8 = 1'b0; s_valid16 = 1'b0; s_data8 = '0; s_data16 = '0;
    repeat (2) @(negedge clk);
    chk1("s_ready_in_reset", s_ready8, 1'b0);
    rst = 1'b0;
    #1;
    chk1("s_ready_after_reset", s_ready8, 1'b1);
    chkw("config_out_reset", cfg8, '0);
    chk1("cfg_valid_reset", valid8, 1'b0);
    chk1("cfg_error_reset", err8, 1'b0);
    chk1("busy_reset", busy8, 1'b0);
    chk1("cfg_done_reset", done8, 1'b0);

    // Good frame: payload 01..21, hand-computed checksum 01.
    for (int k = 0; k < 33; k++) pl[k] = 16'(k + 1);
    frame(1'b0, 1'b1, 16'h0001, 0, 1'b0);
    chk1("s_ready_low_in_commit", s_ready8, 1'b0);
    chk1("cfg_done_not_yet", done8, 1'b0);
    chk1("busy_in_commit", busy8, 1'b1);
    @(negedge clk);
    chk1("cfg_done_pulse", done8, 1'b1);
    chk1("s_ready_back", s_ready8, 1'b1);
    chk8("config_out_lo", cfg8[7:0], 8'h01);
    chk8("config_out_hi", cfg8[263:256], 8'h21);
    chk1("busy_after_commit", busy8, 1'b0);
    @(negedge clk);
    chk1("cfg_done_low_again", done8, 1'b0);
    chk1("cfg_valid_level", valid8, 1'b1);

    // Bad checksum: error flag, committed config untouched.
    frame(1'b0, 1'b1, 16'h0000, 0, 1'b0);
    chk1("cfg_error_set", err8, 1'b1);
    chk1("cfg_valid_kept", valid8, 1'b1);
    chk8("config_kept_lo", cfg8[7:0], 8'h01);
    chk8("config_kept_hi", cfg8[263:256], 8'h21);
    idle(2);
    chk1("cfg_error_sticky", err8, 1'b1);
    for (int k = 0; k < 33; k++) pl[k] = 16'((k * 7 + 3) & 255);
    frame(1'b0, 1'b0, 16'h0000, 0, 1'b1);
    idle(3);

    // Backpressure gaps, then a word held through COMMIT (discarded in IDLE).
    for (int k = 0; k < 33; k++) pl[k] = 16'(k + 1);
    frame(1'b0, 1'b0, 16'h0000, 2, 1'b0);
    send(1'b0, 16'h0000);
    idle(3);

    // Garbage before sync, SYNC value as payload word 0; checksum A5 by hand.
    send(1'b0, 16'h0000);
    send(1'b0, 16'h00FF);
    send(1'b0, 16'h0013);
    chk1("garbage_no_busy", busy8, 1'b0);
    pl[0] = 16'h00A5;
    frame(1'b0, 1'b1, 16'h00A5, 0, 1'b0);
    idle(2);
    chk8("sync_as_payload", cfg8[7:0], 8'hA5);
    chk8("sync_payload_w1", cfg8[15:8], 8'h02);

    // 16-bit instance: reset mid-frame aborts and clears committed config.
    send(1'b1, 16'h00A5);
    for (int k = 0; k < 10; k++) send(1'b1, 16'(16'h1000 + k));
    chk1("busy16_mid_frame", busy16, 1'b1);
    rst = 1'b1;
    @(negedge clk);
    chk1("s_ready16_in_reset", s_ready16, 1'b0);
    chk1("busy16_after_abort", busy16, 1'b0);
    chkw("config_out16_abort", cfg16, '0);
    chkw("config_out8_cleared", cfg8, '0);
    chk1("cfg_valid8_cleared", valid8, 1'b0);
    rst = 1'b0;
    #1;
    chk1("s_ready16_after_reset", s_ready16, 1'b1);
    @(negedge clk);

    // Full 16-bit frame, last word FFFF: payload XOR is FFFF by hand.
    for (int k = 0; k < 16; k++) pl[k] = 16'(16'h1100 + k);
    pl[16] = 16'hFFFF;
    frame(1'b1, 1'b1, 16'hFFFF, 0, 1'b0);
    idle(2);
    chk8("truncated_last_word", cfg16[263:256], 8'hFF);
    chk1("cfg_error16_clear", err16, 1'b0);
    // Checksum that ignores the dropped upper byte must be rejected.
    frame(1'b1, 1'b1, 16'h00FF, 0, 1'b0);
    chk1("cfg_error16_upper_bits", err16, 1'b1);
    chk8("config16_kept", cfg16[263:256], 8'hFF);

    idle(5);
    chk1("scoreboard8_drained", q8.size() == 0, 1'b1);
    chk1("scoreboard16_drained", q16.size() == 0, 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule : tb_sb_config_loader
`default_nettype wire
